// File: rtl/divratio_detector.sv
// Measures clk cycles between rising edges of fin and flags lock to EXPECT or overflow.
// Registered outputs; period_valid strobes the cycle after the closing edge is sampled, no backpressure.
module divratio_detector #(
    parameter int WIDTH    = 8,
    parameter int EXPECT   = 6,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fin,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_TIMEOUT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] EXP_V   = WIDTH'(EXPECT);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] w_period_nxt;
    logic             r_period_valid;
    logic             w_period_valid_nxt;
    logic [3:0]       r_match;
    logic [3:0]       w_match_nxt;
    logic [3:0]       w_match_inc;
    logic             r_locked;
    logic             w_locked_nxt;
    logic             r_overflow;
    logic             w_overflow_nxt;
    logic             r_fin_d;
    logic             w_edge;

    assign w_edge      = fin & ~r_fin_d;
    assign w_match_inc = (r_match >= LOCK_V) ? LOCK_V : r_match + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_match        <= 4'd0;
            r_locked       <= 1'b0;
            r_overflow     <= 1'b0;
            r_fin_d        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_period       <= w_period_nxt;
            r_period_valid <= w_period_valid_nxt;
            r_match        <= w_match_nxt;
            r_locked       <= w_locked_nxt;
            r_overflow     <= w_overflow_nxt;
            r_fin_d        <= fin;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_edge) w_state_nxt = S_MEASURE;
            S_MEASURE: if (!w_edge && r_cnt == CNT_MAX) w_state_nxt = S_TIMEOUT;
            S_TIMEOUT: if (w_edge) w_state_nxt = S_MEASURE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt          = r_cnt;
        w_period_nxt       = r_period;
        w_period_valid_nxt = 1'b0;
        w_match_nxt        = r_match;
        w_locked_nxt       = r_locked;
        w_overflow_nxt     = r_overflow;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = w_edge ? CNT_ONE : '0;
            end
            S_MEASURE: begin
                // An edge on the terminal count still closes a valid interval.
                if (w_edge) begin
                    w_period_nxt       = r_cnt;
                    w_period_valid_nxt = 1'b1;
                    w_cnt_nxt          = CNT_ONE;
                    w_match_nxt        = (r_cnt == EXP_V) ? w_match_inc : 4'd0;
                    w_locked_nxt       = (w_match_nxt == LOCK_V);
                end else if (r_cnt == CNT_MAX) begin
                    w_overflow_nxt = 1'b1;
                    w_locked_nxt   = 1'b0;
                    w_match_nxt    = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_TIMEOUT: begin
                if (w_edge) begin
                    w_overflow_nxt = 1'b0;
                    w_cnt_nxt      = CNT_ONE;
                end
            end
            default: w_cnt_nxt = '0;
        endcase
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_divratio_detector.sv
// Directed bench for divratio_detector: one instance at EXPECT=6, one at EXPECT=2, sharing stimulus.
module tb_divratio_detector;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       fin   = 1'b0;
    logic [7:0] period,  period2;
    logic       pv,      pv2;
    logic       locked,  locked2;
    logic       ovf,     ovf2;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    divratio_detector #(.WIDTH(8), .EXPECT(6), .LOCK_CNT(4)) dut (
        .clk(clk), .reset(reset), .fin(fin),
        .period(period), .period_valid(pv), .locked(locked), .overflow(ovf)
    );

    divratio_detector #(.WIDTH(8), .EXPECT(2), .LOCK_CNT(4)) dut_e2 (
        .clk(clk), .reset(reset), .fin(fin),
        .period(period2), .period_valid(pv2), .locked(locked2), .overflow(ovf2)
    );

    task automatic step(input logic v);
        fin = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic test_reset;
        fin = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({period, pv, locked, ovf} !== 11'd0) begin
            errors++; $display("FAIL reset_async got period=%0d pv=%0b locked=%0b ovf=%0b exp all 0", period, pv, locked, ovf);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({period2, pv2, locked2, ovf2} !== 11'd0) begin
            errors++; $display("FAIL reset_e2 got period=%0d pv=%0b locked=%0b ovf=%0b exp all 0", period2, pv2, locked2, ovf2);
        end
        reset = 1'b0;
    endtask

    task automatic test_lock;
        logic exp_lk;
        step(1'b1);
        checks++;
        if (pv !== 1'b0) begin
            errors++; $display("FAIL lock_first_edge pv=%0b exp 0", pv);
        end
        for (int i = 1; i <= 5; i++) begin
            idle(5);
            step(1'b1);
            exp_lk = (i >= 4);
            checks++;
            if (pv !== 1'b1 || period !== 8'd6) begin
                errors++; $display("FAIL lock_period[%0d] pv=%0b period=%0d exp pv=1 period=6", i, pv, period);
            end
            checks++;
            if (locked !== exp_lk) begin
                errors++; $display("FAIL lock_state[%0d] locked=%0b exp %0b", i, locked, exp_lk);
            end
        end
    endtask

    task automatic test_relock;
        logic exp_lk;
        idle(4);
        step(1'b1);
        checks++;
        if (pv !== 1'b1 || period !== 8'd5 || locked !== 1'b0) begin
            errors++; $display("FAIL relock_short pv=%0b period=%0d locked=%0b exp pv=1 period=5 locked=0", pv, period, locked);
        end
        for (int i = 1; i <= 4; i++) begin
            idle(5);
            step(1'b1);
            exp_lk = (i == 4);
            checks++;
            if (pv !== 1'b1 || period !== 8'd6 || locked !== exp_lk) begin
                errors++; $display("FAIL relock[%0d] pv=%0b period=%0d locked=%0b exp pv=1 period=6 locked=%0b", i, pv, period, locked, exp_lk);
            end
        end
    endtask

    task automatic test_overflow;
        idle(254);
        checks++;
        if (ovf !== 1'b0 || locked !== 1'b1) begin
            errors++; $display("FAIL ovf_early ovf=%0b locked=%0b exp ovf=0 locked=1", ovf, locked);
        end
        idle(1);
        checks++;
        if (ovf !== 1'b1 || locked !== 1'b0 || pv !== 1'b0 || ovf2 !== 1'b1) begin
            errors++; $display("FAIL ovf_assert ovf=%0b locked=%0b pv=%0b ovf2=%0b exp 1 0 0 1", ovf, locked, pv, ovf2);
        end
        idle(5);
        checks++;
        if (ovf !== 1'b1 || period !== 8'd6) begin
            errors++; $display("FAIL ovf_sticky ovf=%0b period=%0d exp ovf=1 period=6", ovf, period);
        end
        step(1'b1);
        checks++;
        if (pv !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_exit pv=%0b ovf=%0b exp pv=0 ovf=0", pv, ovf);
        end
        idle(6);
        step(1'b1);
        checks++;
        if (pv !== 1'b1 || period !== 8'd7) begin
            errors++; $display("FAIL ovf_next_period pv=%0b period=%0d exp pv=1 period=7", pv, period);
        end
        idle(254);
        step(1'b1);
        checks++;
        if (pv !== 1'b1 || period !== 8'd255 || ovf !== 1'b0) begin
            errors++; $display("FAIL max_period pv=%0b period=%0d ovf=%0b exp pv=1 period=255 ovf=0", pv, period, ovf);
        end
    endtask

    task automatic test_alternate;
        logic exp_lk;
        for (int i = 1; i <= 6; i++) begin
            step(1'b0);
            checks++;
            if (pv !== 1'b0) begin
                errors++; $display("FAIL alt_gap[%0d] pv=%0b exp 0", i, pv);
            end
            step(1'b1);
            exp_lk = (i >= 4);
            checks++;
            if (pv !== 1'b1 || period !== 8'd2 || locked !== 1'b0) begin
                errors++; $display("FAIL alt_e6[%0d] pv=%0b period=%0d locked=%0b exp pv=1 period=2 locked=0", i, pv, period, locked);
            end
            checks++;
            if (pv2 !== 1'b1 || period2 !== 8'd2 || locked2 !== exp_lk) begin
                errors++; $display("FAIL alt_e2[%0d] pv=%0b period=%0d locked=%0b exp pv=1 period=2 locked=%0b", i, pv2, period2, locked2, exp_lk);
            end
        end
    endtask

    task automatic test_async_reset;
        for (int i = 1; i <= 4; i++) begin
            idle(5);
            step(1'b1);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL arst_prelock locked=%0b exp 1", locked);
        end
        idle(2);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({period, pv, locked, ovf} !== 11'd0) begin
            errors++; $display("FAIL arst_clear period=%0d pv=%0b locked=%0b ovf=%0b exp all 0", period, pv, locked, ovf);
        end
        idle(2);
        reset = 1'b0;
        step(1'b1);
        checks++;
        if (pv !== 1'b0 || period !== 8'd0) begin
            errors++; $display("FAIL arst_first_edge pv=%0b period=%0d exp pv=0 period=0", pv, period);
        end
        idle(5);
        step(1'b1);
        checks++;
        if (pv !== 1'b1 || period !== 8'd6) begin
            errors++; $display("FAIL arst_resume pv=%0b period=%0d exp pv=1 period=6", pv, period);
        end
    endtask

    task automatic test_fin_high;
        int extra_events;
        extra_events = 0;
        idle(3);
        step(1'b1);
        for (int i = 0; i < 254; i++) begin
            step(1'b1);
            if (pv !== 1'b0 || ovf !== 1'b0) extra_events++;
        end
        checks++;
        if (extra_events !== 0) begin
            errors++; $display("FAIL high_no_strobe events=%0d exp 0", extra_events);
        end
        step(1'b1);
        checks++;
        if (ovf !== 1'b1 || pv !== 1'b0) begin
            errors++; $display("FAIL high_ovf ovf=%0b pv=%0b exp ovf=1 pv=0", ovf, pv);
        end
        for (int i = 0; i < 3; i++) step(1'b1);
        checks++;
        if (ovf !== 1'b1 || pv !== 1'b0 || period !== 8'd4) begin
            errors++; $display("FAIL high_hold ovf=%0b pv=%0b period=%0d exp ovf=1 pv=0 period=4", ovf, pv, period);
        end
    endtask

    initial begin
        test_reset;
        test_lock;
        test_relock;
        test_overflow;
        test_alternate;
        test_async_reset;
        test_fin_high;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
